// File: rtl/div32_seq_if.sv
// div32_seq_if: request/response handshake bundle for the div32_seq sequencer (in_signed only with DIV_SEQ_SIGNED_EN).
interface div32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
`ifdef DIV_SEQ_SIGNED_EN
    logic        in_signed;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quot;
    logic [31:0] out_rem;
    logic        out_dz;
    logic        out_err;

    modport master (
`ifdef DIV_SEQ_SIGNED_EN
        output in_signed,
`endif
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_dz, out_err
    );

    modport slave (
`ifdef DIV_SEQ_SIGNED_EN
        input  in_signed,
`endif
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_dz, out_err
    );
endinterface

// File: rtl/div32_seq.sv
// div32_seq: request/response sequencer around the div32 iterative core; signed support via DIV_SEQ_SIGNED_EN.
module div32_seq #(
    parameter int WDOG_CYC = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    div32_seq_if.slave  bus,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic        dz;
    logic        wdog;
    logic [31:0] mag_a, mag_b, res_q, res_r;

    assign dz            = bus.in_divisor == 32'd0;
    assign wdog          = cnt == 8'(WDOG_CYC - 1);
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == RESP;

`ifdef DIV_SEQ_SIGNED_EN
    logic neg_q, neg_r;

    assign mag_a = (bus.in_signed && bus.in_dividend[31]) ? -bus.in_dividend : bus.in_dividend;
    assign mag_b = (bus.in_signed && bus.in_divisor[31]) ? -bus.in_divisor : bus.in_divisor;
    assign res_q = neg_q ? -div_quot : div_quot;
    assign res_r = neg_r ? -div_rem : div_rem;

    // Remember which result signs need fixing once the unsigned core finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            neg_q <= bus.in_signed && (bus.in_dividend[31] ^ bus.in_divisor[31]);
            neg_r <= bus.in_signed && bus.in_dividend[31];
        end
    end
`else
    assign mag_a = bus.in_dividend;
    assign mag_b = bus.in_divisor;
    assign res_q = div_quot;
    assign res_r = div_rem;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: divide-by-zero skips the core, RUN ends on done or watchdog
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = dz ? RESP : RUN;
            RUN:     if (div_done || wdog) state_next = RESP;
            RESP:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand launch, core start control, watchdog and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_start    <= 1'b0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            cnt          <= 8'd0;
            bus.out_quot <= 32'd0;
            bus.out_rem  <= 32'd0;
            bus.out_dz   <= 1'b0;
            bus.out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (dz) begin
                        bus.out_quot <= 32'hFFFF_FFFF;
                        bus.out_rem  <= bus.in_dividend;
                        bus.out_dz   <= 1'b1;
                    end else begin
                        div_dividend <= mag_a;
                        div_divisor  <= mag_b;
                        div_start    <= 1'b1;
                        cnt          <= 8'd0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 8'd1;
                    if (div_done) begin
                        bus.out_quot <= res_q;
                        bus.out_rem  <= res_r;
                        div_start    <= 1'b0;
                    end else if (wdog) begin
                        bus.out_quot <= 32'd0;
                        bus.out_rem  <= 32'd0;
                        bus.out_err  <= 1'b1;
                        div_start    <= 1'b0;
                    end
                end
                RESP: if (bus.out_ready) begin
                    bus.out_dz  <= 1'b0;
                    bus.out_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/div32_seq.md
# div32_seq

Request/response sequencer that sits directly upstream of the `div32` iterative divider core. It accepts operands on a valid/ready handshake, screens out divide-by-zero, and drives the core's hold-high `start` protocol. It captures quotient and remainder on `done` and presents them on a valid/ready result port. With signed support compiled in, it also performs sign conversion around the unsigned core.

## Interface
- `WDOG_CYC`, default 40: maximum cycles in RUN waiting for `div_done` before abort; legal range 34–255.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: operand request valid.
- `in_ready  out  1`: sequencer can accept a request.
- `in_dividend  in  32`: dividend.
- `in_divisor  in  32`: divisor.
- `in_signed  in  1`: treat operands as two's complement. Present only with `DIV_SEQ_SIGNED_EN`.
- `out_valid  out  1`: result valid.
- `out_ready  in  1`: consumer accepts result.
- `out_quot  out  32`: quotient.
- `out_rem  out  32`: remainder.
- `out_dz  out  1`: divisor was zero.
- `out_err  out  1`: watchdog abort; quotient and remainder are 0.
- `div_start  out  1`: to core `start`, registered.
- `div_dividend  out  32`: to core, registered.
- `div_divisor  out  32`: to core, registered.
- `div_done  in  1`: from core `done`.
- `div_quot  in  32`: from core `yshang`.
- `div_rem  in  32`: from core `yyushu`.

## Operation
- FSM states: IDLE, RUN, RESP. Encoding is free.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch operands.
  - If divisor==0: go to RESP with `out_quot`=32'hFFFFFFFF, `out_rem`=dividend (raw, unconverted), `out_dz`=1. The core is not started.
  - Else: load `div_dividend`/`div_divisor` (magnitudes when signed), set `div_start`=1, clear the watchdog counter, go to RUN.
- RUN:
  - `div_start` held at 1 continuously; the core requires an uninterrupted high `start`.
  - The watchdog counter increments every cycle.
  - On the edge where `div_done`=1 is sampled: capture `div_quot`/`div_rem` (post sign fix), drop `div_start` to 0, go to RESP.
  - The core runs one extra iteration on that same edge. This is harmless because capture uses pre-edge values.
  - If the counter reaches `WDOG_CYC` with no `div_done`: drop `div_start`, set `out_err`=1 with quotient and remainder 0, go to RESP.
- RESP:
  - `out_valid`=1. All outputs are stable until `out_ready`.
  - On `out_valid && out_ready`: go to IDLE and clear `out_dz`/`out_err`.
- Single outstanding request; `in_ready`=0 in RUN and RESP.
- `div_start` must be low for at least one cycle between operations. The RESP→IDLE→RUN path guarantees this, since it lets the core's counter return to 0.

## Timing
- Reset values:
  - `in_ready`=1 (combinational from state IDLE).
  - `out_valid`=0, `div_start`=0.
  - `out_quot`/`out_rem`/`div_dividend`/`div_divisor`=0.
  - `out_dz`=0, `out_err`=0.
  - FSM in IDLE, watchdog counter 0.
- Normal latency, with acceptance edge = E0:
  - `div_start` is high after E0.
  - The core loads at E1 and iterates E2–E33.
  - `div_done` is visible after E33 and sampled at E34.
  - `out_valid`=1 after E34, i.e. 34 cycles.
- Divide-by-zero latency: `out_valid`=1 after E0+1.
- Back-to-back: the next accept is possible at the edge after the `out_ready` handshake.
- Throughput is at best one result per 36 cycles.
- Reset mid-RUN:
  - `div_start` drops asynchronously and the FSM returns to IDLE.
  - The core is reset by the same `rst_n`.
  - No result is emitted.
- `in_valid` while not in IDLE is ignored; the operands are not stored.
- A `div_done` pulse seen outside RUN is ignored.

## Configuration
- `DIV_SEQ_SIGNED_EN`, when defined:
  - Adds the `in_signed` port.
  - When `in_signed`=1: the core receives absolute values, the quotient is negated if operand signs differ, and the remainder takes the dividend's sign.
  - Overflow case 32'h80000000 / 32'hFFFFFFFF returns quotient 32'h80000000, remainder 0.
  - Divide-by-zero output is the same as unsigned.
- When undefined: no `in_signed` port, all operations are unsigned, and no sign logic is synthesized.

## Test plan
- Reset then 100/7 → `out_valid` exactly 34 cycles after accept, quotient 14, remainder 2, `out_dz`=0, `div_start` low the cycle after capture.
- 32'hFFFFFFFF/1 → quotient 32'hFFFFFFFF, remainder 0. Then, with `out_ready` held low for 10 cycles, outputs stay stable and `in_ready` stays 0.
- 55/0 → `out_valid` 1 cycle after accept, quotient 32'hFFFFFFFF, remainder 55, `out_dz`=1, `div_start` never asserted.
- Core model with `div_done` stuck at 0 → `out_err`=1 after `WDOG_CYC` cycles in RUN, quotient and remainder 0, `div_start` low.
- `rst_n` pulsed low 10 cycles into RUN → all outputs return to reset values immediately; a new 9/3 request afterwards returns quotient 3, remainder 0.
- `DIV_SEQ_SIGNED_EN`, signed: -7/2 → quotient -3, remainder -1. 7/-2 → quotient -3, remainder 1. 32'h80000000/-1 → quotient 32'h80000000, remainder 0.
